// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transceiver through a launch/handshake FSM
module uart_tx_feeder #(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter int LAUNCH_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   input  logic              clear_err,
   input  logic              uart_busy,
   output logic              uart_transmit,
   output logic [7:0]        uart_tx_byte,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              tx_active,
   output logic              overflow,
   output logic              launch_err
);
   localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0]     cnt;
   logic              push, pop, timeout;
   assign full      = level == (ADDR_W+1)'(DEPTH);
   assign empty     = level == '0;
   assign tx_active = state != IDLE;
   assign push      = wr_en && !full && !flush;
   assign pop       = state == IDLE && !empty && !uart_busy;
   assign timeout   = state == LAUNCH && !uart_busy && cnt == TW'(LAUNCH_TIMEOUT - 1);
   // byte storage; contents are don't-care after reset so it carries no reset
   always_ff @(posedge clk)
      if (push && !rst) mem[wr_ptr] <= wr_data;
   // pointers, level and the sticky overflow flag; full is judged before any same-cycle pop
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= flush ? '0 : wr_ptr + ADDR_W'(push);
         rd_ptr   <= flush ? '0 : rd_ptr + ADDR_W'(pop);
         level    <= flush ? '0 : level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
         overflow <= (wr_en && full && !flush) ? 1'b1 : clear_err ? 1'b0 : overflow;
      end
   // launch FSM driving the registered transceiver request and the launch error flag
   always_ff @(posedge clk)
      if (rst) begin
         state         <= IDLE;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= 8'h00;
         cnt           <= '0;
         launch_err    <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (pop) begin
                  uart_tx_byte  <= mem[rd_ptr];
                  uart_transmit <= 1'b1;
                  cnt           <= '0;
                  state         <= LAUNCH;
               end
            LAUNCH:
               if (uart_busy) begin
                  uart_transmit <= 1'b0;
                  state         <= WAIT_DONE;
               end else if (timeout) begin
                  uart_transmit <= 1'b0;
                  state         <= IDLE;
               end else cnt <= cnt + 1'b1;
            WAIT_DONE:
               if (!uart_busy) state <= IDLE;
            default: state <= IDLE;
         endcase
         launch_err <= timeout ? 1'b1 : clear_err ? 1'b0 : launch_err;
      end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO entries, power of two, 4..256.
REQ-002 SHALL have parameter ADDR_W, default 4; log2(DEPTH).
REQ-003 SHALL have parameter LAUNCH_TIMEOUT, default 8; maximum cycles to wait for uart_busy to rise after the launch.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  push request.
REQ-007 SHALL have port wr_data  input  8  byte to queue.
REQ-008 SHALL have port flush  input  1  discard all queued bytes.
REQ-009 SHALL have port clear_err  input  1  clear the sticky error flags.
REQ-010 SHALL have port uart_busy  input  1  transceiver is_transmitting.
REQ-011 SHALL have port uart_transmit  output  1  registered transmit request to the transceiver.
REQ-012 SHALL have port uart_tx_byte  output  8  registered byte to the transceiver.
REQ-013 SHALL have the FIFO status ports full, empty (output 1), level (output ADDR_W+1) and tx_active (output 1, FSM not IDLE).
REQ-014 SHALL have ports overflow and launch_err  output  1  sticky error flags.

Function
REQ-015 SHALL store bytes in a DEPTH-entry circular buffer with ADDR_W-bit read/write pointers wrapping DEPTH-1 -> 0; level counts 0..DEPTH.
REQ-016 SHALL derive full = (level==DEPTH) and empty = (level==0), both combinational from level.
REQ-017 SHALL accept a push when wr_en=1, full=0 and flush=0: write at wr_ptr, wr_ptr+1, level+1 at that edge.
REQ-018 SHALL, on wr_en=1 while full=1, drop the byte, leave pointers and level unchanged, and set overflow.
REQ-019 SHALL evaluate full before any same-cycle pop; a push while full is rejected even when a pop occurs in that cycle.
REQ-020 SHALL leave level unchanged for a same-cycle accepted push and pop.
REQ-021 SHALL use a 3-state FSM: IDLE, LAUNCH, WAIT_DONE.
REQ-022 SHALL, in IDLE with empty=0 and uart_busy=0: load uart_tx_byte from the head, pop (rd_ptr+1, level-1), set uart_transmit=1, go to LAUNCH.
REQ-023 SHALL give a 1-cycle latency: a byte pushed at edge k into an empty FIFO in IDLE shows uart_transmit=1 after edge k+1.
REQ-024 SHALL, in LAUNCH, hold uart_transmit=1 and uart_tx_byte stable; on uart_busy=1, clear uart_transmit and go to WAIT_DONE.
REQ-025 SHALL count LAUNCH cycles; if LAUNCH_TIMEOUT cycles elapse without uart_busy=1, clear uart_transmit, set launch_err, discard the byte and return to IDLE.
REQ-026 SHALL, in WAIT_DONE, hold uart_transmit=0 and return to IDLE on the first cycle uart_busy=0; a back-to-back launch is permitted from that IDLE cycle.
REQ-027 SHALL make flush=1 zero the pointers and level at that edge and drop any same-cycle wr_en without setting overflow; the FSM and an in-flight byte are unaffected.
REQ-028 SHALL make clear_err=1 clear overflow and launch_err; a same-cycle set event wins.
REQ-029 SHALL hold uart_tx_byte at its last launched value outside LAUNCH.

Reset
REQ-030 SHALL, on rst=1 at a rising edge: FSM to IDLE, pointers=0, level=0, uart_transmit=0, uart_tx_byte=8'h00, overflow=0, launch_err=0, timeout counter=0.
REQ-031 SHALL let rst override all other inputs, including mid-LAUNCH or mid-WAIT_DONE; queued bytes are lost and buffer contents are don't-care.
REQ-032 SHALL ignore wr_en, flush and clear_err during the rst cycle.

Verification
REQ-033 SHALL cover: after reset, push 8'hA5 into empty FIFO -> uart_transmit=1 next cycle, uart_tx_byte=8'hA5; model busy after 2 cycles -> transmit drops next cycle; busy falls -> IDLE, empty=1.
REQ-034 SHALL cover: push 16 bytes 8'h00..8'h0F with busy held 1 -> full=1, level=16; 17th push 8'hFF -> overflow=1, level stays 16; release busy -> bytes emerge 00..0F in order, no FF.
REQ-035 SHALL cover: uart_busy tied 0, push 8'h3C -> after 8 LAUNCH cycles uart_transmit=0, launch_err=1, level=0; clear_err -> launch_err=0.
REQ-036 SHALL cover: fill 5 bytes, assert flush with a same-cycle wr_en -> level=0, empty=1, overflow=0, in-flight byte still completes.
REQ-037 SHALL cover: rst asserted in LAUNCH with 3 bytes queued -> next cycle uart_transmit=0, tx_active=0, level=0, uart_tx_byte=8'h00.
REQ-038 SHALL cover pointer wrap: 40 bytes streamed through with interleaved push/pop -> output order exact, level never exceeds 16.
